// File: rtl/serial_word_deserializer.sv
// Sync-hunting serial-to-word deserializer with a 2-entry valid/ready output FIFO.
// Define SERIAL_DESER_PARITY_EN to expect an even-parity bit after every word (WIDTH+1 bits per word).
module serial_word_deserializer #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] SYNC = WIDTH'(8'hA5)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit,
  input  logic             i_bit_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_locked,
  output logic             o_overflow,
  output logic             o_parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] W_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] W_LAST = CW'(WIDTH - 1);

`ifdef SERIAL_DESER_PARITY_EN
  typedef enum logic [1:0] {ST_HUNT, ST_COLLECT, ST_PARITY} state_t;
`else
  typedef enum logic [1:0] {ST_HUNT, ST_COLLECT} state_t;
`endif

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_win, w_win;
  logic [CW-1:0]    r_fill, w_fill;
  logic [CW-1:0]    r_bcnt, w_bcnt;
  logic [WIDTH-1:0] r_e0, w_e0;
  logic [WIDTH-1:0] r_e1, w_e1;
  logic [1:0]       r_cnt, w_cnt;
  logic             r_locked;
  logic             r_overflow, w_overflow;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_push;
  logic             w_pop;
  logic             w_accept;
`ifdef SERIAL_DESER_PARITY_EN
  logic             r_perr, w_perr;
`endif

  always_comb begin
    w_state    = r_state;
    w_win      = r_win;
    w_fill     = r_fill;
    w_bcnt     = r_bcnt;
    w_e0       = r_e0;
    w_e1       = r_e1;
    w_cnt      = r_cnt;
    w_overflow = r_overflow;
    w_shift    = {r_win[WIDTH-2:0], i_bit};
    w_word     = w_shift;
    w_push     = 1'b0;
    w_pop      = (r_cnt != 2'd0) && i_ready;
`ifdef SERIAL_DESER_PARITY_EN
    w_perr     = 1'b0;
`endif

    if (i_bit_valid) begin
      w_win = w_shift;
      case (r_state)
        ST_HUNT: begin
          if (r_fill != W_FULL) w_fill = r_fill + 1'b1;
          if ((r_fill == W_FULL || r_fill == W_LAST) && w_shift == SYNC) begin
            w_state = ST_COLLECT;
            w_bcnt  = '0;
          end
        end
        ST_COLLECT: begin
          if (r_bcnt == W_LAST) begin
            w_bcnt = '0;
`ifdef SERIAL_DESER_PARITY_EN
            w_state = ST_PARITY;
`else
            w_push = 1'b1;
`endif
          end else begin
            w_bcnt = r_bcnt + 1'b1;
          end
        end
`ifdef SERIAL_DESER_PARITY_EN
        // The window has not yet shifted in the parity bit, so it still holds the word.
        ST_PARITY: begin
          if (^{r_win, i_bit}) begin
            w_perr  = 1'b1;
            w_state = ST_HUNT;
            w_fill  = '0;
          end else begin
            w_push  = 1'b1;
            w_word  = r_win;
            w_state = ST_COLLECT;
          end
        end
`endif
        default: w_state = ST_HUNT;
      endcase
    end

    // A full FIFO still takes the word when the head leaves on the same edge.
    w_accept = w_push && ((r_cnt != 2'd2) || w_pop);
    if (w_push && !w_accept) begin
      w_overflow = 1'b1;
      w_state    = ST_HUNT;
      w_fill     = '0;
    end

    case ({w_accept, w_pop})
      2'b10: begin
        if (r_cnt == 2'd0) w_e0 = w_word;
        else               w_e1 = w_word;
        w_cnt = r_cnt + 1'b1;
      end
      2'b01: begin
        if (r_cnt == 2'd2) w_e0 = r_e1;
        w_cnt = r_cnt - 1'b1;
      end
      2'b11: begin
        if (r_cnt == 2'd2) begin
          w_e0 = r_e1;
          w_e1 = w_word;
        end else begin
          w_e0 = w_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_HUNT;
      r_win      <= '0;
      r_fill     <= '0;
      r_bcnt     <= '0;
      r_e0       <= '0;
      r_e1       <= '0;
      r_cnt      <= 2'd0;
      r_locked   <= 1'b0;
      r_overflow <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      r_perr     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_win      <= w_win;
      r_fill     <= w_fill;
      r_bcnt     <= w_bcnt;
      r_e0       <= w_e0;
      r_e1       <= w_e1;
      r_cnt      <= w_cnt;
      r_locked   <= (w_state != ST_HUNT);
      r_overflow <= w_overflow;
`ifdef SERIAL_DESER_PARITY_EN
      r_perr     <= w_perr;
`endif
    end
  end

  assign o_data     = r_e0;
  assign o_valid    = (r_cnt != 2'd0);
  assign o_locked   = r_locked;
  assign o_overflow = r_overflow;
`ifdef SERIAL_DESER_PARITY_EN
  assign o_parity_err = r_perr;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Bench for serial_word_deserializer: directed scenarios plus randomized traffic against a queue-based model.
module tb_serial_word_deserializer;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_bit = 1'b0;
  logic       i_bit_valid = 1'b0;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_locked;
  logic       o_overflow;
  logic       o_parity_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sync_v = 8'hA5;

  serial_word_deserializer #(.WIDTH(8), .SYNC(8'hA5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bit(i_bit), .i_bit_valid(i_bit_valid),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_locked(o_locked),
    .o_overflow(o_overflow), .o_parity_err(o_parity_err)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: bit history, a lock flag, a bits-since-lock count and a word queue.
  logic [7:0] m_win;
  int         m_fill;
  int         m_n;
  bit         m_locked;
  bit         m_ovf;
  bit         m_perr;
  logic [7:0] m_word;
  logic [7:0] m_data;
  logic [7:0] q[$];

  task automatic model_reset();
    m_win = 8'h00; m_fill = 0; m_n = 0; m_locked = 0; m_ovf = 0; m_perr = 0;
    m_word = 8'h00; m_data = 8'h00; q.delete();
  endtask

  task automatic model_step(input logic b, input logic v, input logic r);
    bit         have;
    logic [7:0] w;
    have = 0;
    w = 8'h00;
    m_perr = 0;
    if (q.size() > 0 && r) void'(q.pop_front());
    if (v) begin
      m_win = 8'((m_win * 2) + b);
      if (!m_locked) begin
        if (m_fill < 8) m_fill++;
        if (m_fill == 8 && m_win == 8'hA5) begin
          m_locked = 1;
          m_n = 0;
        end
      end else begin
        m_n++;
`ifdef SERIAL_DESER_PARITY_EN
        if (m_n == 8) m_word = m_win;
        else if (m_n == 9) begin
          m_n = 0;
          if ((($countones(m_word) + b) % 2) == 0) begin
            have = 1; w = m_word;
          end else begin
            m_perr = 1; m_locked = 0; m_fill = 0;
          end
        end
`else
        if (m_n == 8) begin
          m_n = 0; have = 1; w = m_win;
        end
`endif
      end
      if (have) begin
        if (q.size() < 2) q.push_back(w);
        else begin
          m_ovf = 1; m_locked = 0; m_fill = 0;
        end
      end
    end
    if (q.size() > 0) m_data = q[0];
  endtask

  task automatic step(input logic b, input logic v, input logic r);
    i_bit = b; i_bit_valid = v; i_ready = r;
    @(posedge i_clk);
    model_step(b, v, r);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] w, input logic r);
    for (int i = 7; i >= 0; i--) step(w[i], 1'b1, r);
  endtask

  // Sends one data word (plus its correct parity bit in the parity build); r_last applies to the final bit.
  task automatic send_data(input logic [7:0] w, input logic r_body, input logic r_last);
`ifdef SERIAL_DESER_PARITY_EN
    send_bits(w, r_body);
    step(^w, 1'b1, r_last);
`else
    for (int i = 7; i >= 1; i--) step(w[i], 1'b1, r_body);
    step(w[0], 1'b1, r_last);
`endif
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_bit_valid = 1'b0; i_ready = 1'b0; i_bit = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({o_valid, o_locked, o_overflow, o_parity_err, o_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: v=%b l=%b ovf=%b perr=%b data=%h expected all 0",
               o_valid, o_locked, o_overflow, o_parity_err, o_data);
    end
    send_bits(8'hA5, 1'b0);
    send_data(8'h5A, 1'b0, 1'b0);
    n_tests++;
    if (o_valid !== 1'b1 || o_locked !== 1'b1 || o_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL reset_precond: v=%b l=%b data=%h expected 1 1 5a", o_valid, o_locked, o_data);
    end
    #2;
    i_rst = 1'b1;
    #1;
    n_tests++;
    if ({o_valid, o_locked, o_overflow, o_parity_err, o_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset: v=%b l=%b ovf=%b perr=%b data=%h expected all 0",
               o_valid, o_locked, o_overflow, o_parity_err, o_data);
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
    send_bits(8'h5A, 1'b1);
    n_tests++;
    if (o_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL no_lock_without_sync: o_locked=%b expected 0", o_locked);
    end
  endtask

  task automatic test_lock_data();
    do_reset();
    for (int i = 7; i >= 1; i--) step(sync_v[i], 1'b1, 1'b1);
    n_tests++;
    if (o_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_early: o_locked=%b expected 0", o_locked);
    end
    step(sync_v[0], 1'b1, 1'b1);
    n_tests++;
    if (o_locked !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_rise: o_locked=%b o_valid=%b expected 1 0", o_locked, o_valid);
    end
    send_data(8'h3C, 1'b1, 1'b1);
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL word_out: o_valid=%b o_data=%h expected 1 3c", o_valid, o_data);
    end
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (o_valid !== 1'b0 || o_locked !== 1'b1 || o_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL word_one_cycle: o_valid=%b o_locked=%b o_data=%h expected 0 1 3c",
               o_valid, o_locked, o_data);
    end
  endtask

  task automatic test_overlap();
    logic [11:0] pat;
    pat = 12'hAA5;
    do_reset();
    for (int i = 11; i >= 1; i--) step(pat[i], 1'b1, 1'b1);
    n_tests++;
    if (o_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL overlap_early: o_locked=%b expected 0", o_locked);
    end
    step(pat[0], 1'b1, 1'b1);
    n_tests++;
    if (o_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL overlap_lock: o_locked=%b expected 1", o_locked);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] d;
    bit         bits[$];
    d = 8'hC3;
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      step(sync_v[i], 1'b1, 1'b1);
      step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    n_tests++;
    if (o_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_lock: o_locked=%b expected 1", o_locked);
    end
    for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
`ifdef SERIAL_DESER_PARITY_EN
    bits.push_back(^d);
`endif
    while (bits.size() > 1) begin
      step(bits.pop_front(), 1'b1, 1'b1);
      step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    step(bits.pop_front(), 1'b1, 1'b1);
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL gap_word: o_valid=%b o_data=%h expected 1 c3", o_valid, o_data);
    end
    step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    n_tests++;
    if (o_valid !== 1'b0 || o_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_after: o_valid=%b o_locked=%b expected 0 1", o_valid, o_locked);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_bits(8'hA5, 1'b0);
    send_data(8'h11, 1'b0, 1'b0);
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== 8'h11) begin
      n_fail++;
      $display("FAIL bp_first: o_valid=%b o_data=%h expected 1 11", o_valid, o_data);
    end
    send_data(8'h22, 1'b0, 1'b0);
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== 8'h11 || o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: o_valid=%b o_data=%h o_overflow=%b expected 1 11 0", o_valid, o_data, o_overflow);
    end
    send_data(8'h33, 1'b0, 1'b0);
    n_tests++;
    if (o_overflow !== 1'b1 || o_locked !== 1'b0 || o_data !== 8'h11) begin
      n_fail++;
      $display("FAIL bp_drop: o_overflow=%b o_locked=%b o_data=%h expected 1 0 11", o_overflow, o_locked, o_data);
    end
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== 8'h22) begin
      n_fail++;
      $display("FAIL bp_pop1: o_valid=%b o_data=%h expected 1 22", o_valid, o_data);
    end
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (o_valid !== 1'b0 || o_data !== 8'h22 || o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pop2: o_valid=%b o_data=%h o_overflow=%b expected 0 22 1", o_valid, o_data, o_overflow);
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    send_bits(8'hA5, 1'b0);
    send_data(8'h11, 1'b0, 1'b0);
    send_data(8'h22, 1'b0, 1'b0);
    send_data(8'h33, 1'b0, 1'b1);
    n_tests++;
    if (o_overflow !== 1'b0 || o_locked !== 1'b1 || o_valid !== 1'b1 || o_data !== 8'h22) begin
      n_fail++;
      $display("FAIL se_no_ovf: ovf=%b l=%b v=%b data=%h expected 0 1 1 22", o_overflow, o_locked, o_valid, o_data);
    end
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== 8'h33) begin
      n_fail++;
      $display("FAIL se_third: o_valid=%b o_data=%h expected 1 33", o_valid, o_data);
    end
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL se_empty: o_valid=%b expected 0", o_valid);
    end
  endtask

`ifdef SERIAL_DESER_PARITY_EN
  task automatic test_parity();
    do_reset();
    send_bits(8'hA5, 1'b1);
    send_bits(8'h3C, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (o_valid !== 1'b1 || o_data !== 8'h3C || o_parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL par_good: v=%b data=%h perr=%b expected 1 3c 0", o_valid, o_data, o_parity_err);
    end
    send_bits(8'h3C, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    n_tests++;
    if (o_parity_err !== 1'b1 || o_valid !== 1'b0 || o_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL par_bad: perr=%b v=%b l=%b expected 1 0 0", o_parity_err, o_valid, o_locked);
    end
    step(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (o_parity_err !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL par_pulse_once: perr=%b v=%b expected 0 0", o_parity_err, o_valid);
    end
  endtask
`endif

  task automatic test_random();
    bit          inj[$];
    logic        b, v, r;
    logic [11:0] got, exp;
    int          shown;
    shown = 0;
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      for (int k = 7; k >= 0; k--) inj.push_back(sync_v[k]);
      for (int c = 0; c < 400; c++) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 99) < (10 + 16 * seg));
        if (v && inj.size() > 0) b = inj.pop_front();
        else b = 1'($urandom_range(0, 1));
        step(b, v, r);
        if (!m_locked && inj.size() == 0 && $urandom_range(0, 31) == 0)
          for (int k = 7; k >= 0; k--) inj.push_back(sync_v[k]);
        got = {o_valid, o_locked, o_overflow, o_parity_err, o_data};
        exp = {(q.size() > 0), m_locked, m_ovf, m_perr, m_data};
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          if (shown < 10)
            $display("FAIL random seg%0d cyc%0d: {v,l,ovf,perr,data}=%h expected %h", seg, c, got, exp);
          shown++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_data();
    test_overlap();
    test_gapped();
    test_backpressure();
    test_same_edge();
`ifdef SERIAL_DESER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
